// File: rtl/irom_banked_fetch.sv
// Banked instruction ROM: even/odd word banks return a full 32-bit instruction from any
// halfword-aligned PC, spanning word boundaries, in one pipelined transaction.
// Optional fetch/spill counters are enabled by defining IROM_STATS_EN.
module irom_banked_fetch #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [63:0] IROM_BASE = 64'h1000,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned ZCA       = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_adr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_instr,
  output logic            rsp_compressed,
  output logic            rsp_fault
`ifdef IROM_STATS_EN
  ,
  output logic [31:0]     stat_fetch,
  output logic [31:0]     stat_spill
`endif
);
  localparam int unsigned Offset    = $clog2(XLEN / 8);
  localparam int unsigned HalfW     = Offset - 1;
  localparam int unsigned ShiftW    = HalfW + 4;
  localparam int unsigned RegionW   = ADDR_BITS + Offset;
  localparam int unsigned BankDepth = 2 ** (ADDR_BITS - 1);
  localparam int unsigned SpillMin  = XLEN - 32;
  localparam logic [XLEN-1:0] Base     = IROM_BASE[XLEN-1:0];
  localparam logic [XLEN-1:0] BootWord = {(XLEN / 32){32'h0000_0013}};

  logic [XLEN-1:0] mem_even [BankDepth] = '{default: BootWord};
  logic [XLEN-1:0] mem_odd  [BankDepth] = '{default: BootWord};

  typedef struct packed {
    logic             valid;
    logic             fault;
    logic             w_odd;
    logic [HalfW-1:0] h;
    logic [XLEN-1:0]  even;
    logic [XLEN-1:0]  odd;
  } stage_t;

  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_instr_q, rsp_instr_d;
  logic                 rsp_compressed_q, rsp_compressed_d;
  logic                 rsp_fault_q, rsp_fault_d;
  logic                 advance;
  stage_t               req_stage, last_stage;
  logic [XLEN-1:0]      off;
  logic [ADDR_BITS-1:0] w;
  logic [ADDR_BITS-2:0] even_addr, odd_addr;

  assign advance   = ~rsp_valid_q | rsp_ready;
  assign req_ready = advance;

  always_comb begin
    off = req_adr - Base;
    w   = off[RegionW-1:Offset];
    // An odd word's successor sits in the even bank one row further up (wrapping to row 0).
    odd_addr  = w[ADDR_BITS-1:1];
    even_addr = w[ADDR_BITS-1:1] + (ADDR_BITS - 1)'(w[0]);
    req_stage.valid = req_valid;
    req_stage.fault = (req_adr < Base) || (off[XLEN-1:RegionW] != '0) || off[0] ||
                      ((ZCA == 0) && off[1]);
    req_stage.w_odd = w[0];
    req_stage.h     = off[Offset-1:1];
    req_stage.even  = mem_even[even_addr];
    req_stage.odd   = mem_odd[odd_addr];
  end

  if (LATENCY > 1) begin : g_pipe
    stage_t pipe_q [LATENCY-1];
    stage_t pipe_d [LATENCY-1];

    always_comb begin
      pipe_d[0] = advance ? req_stage : pipe_q[0];
      for (int i = 1; i < LATENCY - 1; i++) begin
        pipe_d[i] = advance ? pipe_q[i-1] : pipe_q[i];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign last_stage = pipe_q[LATENCY-2];
  end else begin : g_flat
    assign last_stage = req_stage;
  end

  logic [XLEN-1:0]   lo_word, hi_word;
  logic [2*XLEN-1:0] pair;
  logic [ShiftW-1:0] shift;
  logic [31:0]       raw_instr, asm_instr;
  logic              asm_compressed;

  always_comb begin
    lo_word        = last_stage.w_odd ? last_stage.odd : last_stage.even;
    hi_word        = last_stage.w_odd ? last_stage.even : last_stage.odd;
    pair           = {hi_word, lo_word};
    shift          = {last_stage.h, 4'b0000};
    raw_instr      = pair[shift +: 32];
    asm_instr      = raw_instr;
    asm_compressed = 1'b0;
    if (last_stage.fault) begin
      asm_instr = '0;
    end else if ((ZCA != 0) && (raw_instr[1:0] != 2'b11)) begin
      asm_instr      = {16'h0000, raw_instr[15:0]};
      asm_compressed = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d      = rsp_valid_q;
    rsp_instr_d      = rsp_instr_q;
    rsp_compressed_d = rsp_compressed_q;
    rsp_fault_d      = rsp_fault_q;
    if (advance) begin
      rsp_valid_d = last_stage.valid;
      if (last_stage.valid) begin
        rsp_instr_d      = asm_instr;
        rsp_compressed_d = asm_compressed;
        rsp_fault_d      = last_stage.fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q      <= 1'b0;
      rsp_instr_q      <= '0;
      rsp_compressed_q <= 1'b0;
      rsp_fault_q      <= 1'b0;
    end else begin
      rsp_valid_q      <= rsp_valid_d;
      rsp_instr_q      <= rsp_instr_d;
      rsp_compressed_q <= rsp_compressed_d;
      rsp_fault_q      <= rsp_fault_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_instr      = rsp_instr_q;
  assign rsp_compressed = rsp_compressed_q;
  assign rsp_fault      = rsp_fault_q;

`ifdef IROM_STATS_EN
  logic [31:0] stat_fetch_q, stat_fetch_d;
  logic [31:0] stat_spill_q, stat_spill_d;
  logic        asm_spill;

  always_comb begin
    asm_spill    = !last_stage.fault && !asm_compressed && (shift > SpillMin[ShiftW-1:0]);
    stat_fetch_d = stat_fetch_q;
    stat_spill_d = stat_spill_q;
    if (req_valid && advance && !req_stage.fault && (stat_fetch_q != '1)) begin
      stat_fetch_d = stat_fetch_q + 32'd1;
    end
    if (advance && last_stage.valid && asm_spill && (stat_spill_q != '1)) begin
      stat_spill_d = stat_spill_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_fetch_q <= '0;
      stat_spill_q <= '0;
    end else begin
      stat_fetch_q <= stat_fetch_d;
      stat_spill_q <= stat_spill_d;
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_spill = stat_spill_q;
`endif

endmodule

// File: tb/tb_irom_banked_fetch.sv
// Self-checking bench for irom_banked_fetch: byte-addressed ROM model plus scoreboard on a
// LATENCY=3 instance, and a LATENCY=1 instance for single-cycle directed fetches.
module tb_irom_banked_fetch;
  localparam logic [63:0] BASE      = 64'h1000;
  localparam int unsigned WORDS     = 1024;
  localparam int unsigned ROM_BYTES = 8192;

  typedef struct packed {
    logic        fault;
    logic        comp;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_compressed, rsp_fault;
  logic [63:0] req_adr;
  logic [31:0] rsp_instr;
  logic        l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_compressed, l1_rsp_fault;
  logic [63:0] l1_req_adr;
  logic [31:0] l1_rsp_instr;
`ifdef IROM_STATS_EN
  logic [31:0] stat_fetch, stat_spill, l1_stat_fetch, l1_stat_spill;
`endif

  always #5 clk = ~clk;

  irom_banked_fetch #(
    .XLEN(64), .ADDR_BITS(10), .IROM_BASE(64'h1000), .LATENCY(3), .ZCA(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_adr(req_adr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_compressed(rsp_compressed), .rsp_fault(rsp_fault)
`ifdef IROM_STATS_EN
    , .stat_fetch(stat_fetch), .stat_spill(stat_spill)
`endif
  );

  irom_banked_fetch #(
    .XLEN(64), .ADDR_BITS(10), .IROM_BASE(64'h1000), .LATENCY(1), .ZCA(1)
  ) u_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_adr(l1_req_adr), .rsp_valid(l1_rsp_valid), .rsp_ready(1'b1),
    .rsp_instr(l1_rsp_instr), .rsp_compressed(l1_rsp_compressed), .rsp_fault(l1_rsp_fault)
`ifdef IROM_STATS_EN
    , .stat_fetch(l1_stat_fetch), .stat_spill(l1_stat_spill)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          retired = 0;
  logic [63:0] rom [WORDS];
  exp_t        sb [$];
  logic        stall_seen = 1'b0;
  exp_t        held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Model works on bytes: fetch halfword at off and the next one, wrapping over the region.
  function automatic exp_t model(input logic [63:0] a);
    exp_t        e;
    logic [63:0] off;
    int unsigned b0, b1;
    logic [15:0] h0, h1;
    e   = '0;
    off = a - BASE;
    if (a < BASE || off >= 64'(ROM_BYTES) || off[0]) begin
      e.fault = 1'b1;
      return e;
    end
    b0 = 32'(off);
    b1 = (b0 + 2) % ROM_BYTES;
    h0 = 16'(rom[b0 / 8] >> ((b0 % 8) * 8));
    h1 = 16'(rom[b1 / 8] >> ((b1 % 8) * 8));
    if (h0[1:0] != 2'b11) begin
      e.comp  = 1'b1;
      e.instr = {16'h0000, h0};
    end else begin
      e.instr = {h1, h0};
    end
    return e;
  endfunction

  task automatic put_word(input int unsigned i, input logic [63:0] v);
    rom[i] = v;
    if (i[0]) begin
      dut.mem_odd[9'(i >> 1)]  = v;
      u_l1.mem_odd[9'(i >> 1)] = v;
    end else begin
      dut.mem_even[9'(i >> 1)]  = v;
      u_l1.mem_even[9'(i >> 1)] = v;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_data", 64'({rsp_fault, rsp_compressed, rsp_instr}), 64'(held));
      end
      if (rsp_valid && !rsp_ready) check("stall_req_ready", 64'(req_ready), 64'd0);
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got instr %h with no request outstanding", rsp_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({rsp_fault, rsp_compressed, rsp_instr} !== e) begin
            errors++;
            $display("FAIL rsp: got %h, want %h", {rsp_fault, rsp_compressed, rsp_instr}, e);
          end
        end
        retired++;
      end
      if (req_valid && req_ready) sb.push_back(model(req_adr));
      stall_seen = rsp_valid && !rsp_ready;
      held       = {rsp_fault, rsp_compressed, rsp_instr};
    end
  end

  task automatic fetch_one(input logic [63:0] a, output exp_t got, output exp_t got1,
                           output int lat);
    int n;
    @(posedge clk);
    #1;
    rsp_ready    = 1'b1;
    req_adr      = a;
    req_valid    = 1'b1;
    l1_req_adr   = a;
    l1_req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    l1_req_valid = 1'b0;
    @(negedge clk);
    check("l1_valid", 64'(l1_rsp_valid), 64'd1);
    got1 = {l1_rsp_fault, l1_rsp_compressed, l1_rsp_instr};
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = n + 1;
    got = {rsp_fault, rsp_compressed, rsp_instr};
  endtask

  task automatic directed(input string name, input logic [63:0] a, input exp_t want);
    exp_t got, got1;
    int   lat;
    fetch_one(a, got, got1, lat);
    check(name, 64'(got), 64'(want));
    check({name, "_l1"}, 64'(got1), 64'(want));
    check({name, "_lat"}, 64'(lat), 64'd3);
  endtask

  task automatic stream_phase();
    int n;
    int r0;
    r0 = retired;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          req_adr   = BASE + 64'(16 + 6 * k);
          req_valid = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!req_ready && n < 20);
          if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL stream_accept: request %0d not accepted within 20 cycles", k);
          end
          @(posedge clk);
          #1;
        end
        req_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stream_count", 64'(retired - r0), 64'd8);
  endtask

  initial begin
    int unsigned seen;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_adr      = BASE;
    rsp_ready    = 1'b1;
    l1_req_valid = 1'b0;
    l1_req_adr   = BASE;
    repeat (3) @(posedge clk);
    for (int i = 0; i < WORDS; i++) put_word(i, {$urandom(), $urandom()});
    @(negedge clk);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_data", 64'({rsp_fault, rsp_compressed, rsp_instr}), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_l1_valid", 64'(l1_rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    put_word(0, 64'h0000_0013_0000_0093);
    directed("aligned", BASE, {2'b00, 32'h0000_0093});
    put_word(0, 64'h4503_0013_4505_0093);
    put_word(1, 64'h1111_2222_3333_0010);
    directed("spill", BASE + 64'd6, {2'b00, 32'h0010_4503});
`ifdef IROM_STATS_EN
    check("stat_spill_1", 64'(stat_spill), 64'd1);
`endif
    directed("compressed", BASE + 64'd2, {2'b01, 32'h0000_4505});
    put_word(1023, 64'h0537_5555_6666_7777);
    put_word(0, 64'h4503_0013_4505_1234);
    directed("wrap", BASE + 64'd8190, {2'b00, 32'h1234_0537});
    directed("fault_range", BASE + 64'd8192, {2'b10, 32'h0});
    directed("fault_odd", BASE + 64'd1, {2'b10, 32'h0});
    directed("fault_below", BASE - 64'd2, {2'b10, 32'h0});
`ifdef IROM_STATS_EN
    check("stat_fetch", 64'(stat_fetch), 64'd4);
    check("stat_spill_2", 64'(stat_spill), 64'd2);
`endif

    @(posedge clk);
    #1;
    stream_phase();

    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_adr   = BASE;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_adr = BASE + 64'd4;
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("inflight_reset_valid", 64'(rsp_valid), 64'd0);
    check("inflight_reset_instr", 64'(rsp_instr), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_stale_rsp", 64'(seen), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
